// File: rtl/row_classifier_pkg.sv
// Shared types and constants for the row classifier.
package classifier_pkg;

    localparam int unsigned NUM_CLASSES = 10;

    // Saturation rails for 16-bit row results.
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StStore,
        StNext,
        StFin
    } state_e;

endpackage

// File: rtl/row_classifier_if.sv
// Bundles the multiplier handshake, controller status and score read port.
interface row_classifier_if #(
    parameter int unsigned RESULT_W = 16
);
    logic                start;
    logic                done_row;
    logic [RESULT_W-1:0] row_result;
    logic                overflow;
    logic [3:0]          row_select;
    logic                begin_mult;
    logic                busy;
    logic                done;
    logic [3:0]          class_out;
    logic [RESULT_W-1:0] class_score;
    logic                any_overflow;
    logic [3:0]          score_rd_addr;
    logic [RESULT_W-1:0] score_rd_data;

    // Environment side: controller plus multiplier.
    modport master (
        output start, done_row, row_result, overflow, score_rd_addr,
        input  row_select, begin_mult, busy, done, class_out, class_score,
        input  any_overflow, score_rd_data
    );

    // Classifier side.
    modport slave (
        input  start, done_row, row_result, overflow, score_rd_addr,
        output row_select, begin_mult, busy, done, class_out, class_score,
        output any_overflow, score_rd_data
    );
endinterface

// File: rtl/row_classifier_score_buffer.sv
// Per-class score register file with a combinational, range-checked read port.
module score_buffer #(
    parameter int unsigned NUM_ROWS = 10,
    parameter int unsigned RESULT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [3:0]          waddr,
    input  logic [RESULT_W-1:0] wdata,
    input  logic [3:0]          raddr,
    output logic [RESULT_W-1:0] rdata
);

    logic [RESULT_W-1:0] mem_q [NUM_ROWS];
    logic [RESULT_W-1:0] mem_d [NUM_ROWS];

    // Next-state: write one entry when enabled and in range.
    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < NUM_ROWS)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port: addresses past the last row read as zero.
    always_comb begin
        rdata = '0;
        if (32'(raddr) < NUM_ROWS) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/row_classifier.sv
// Sequences output rows through the multiplier, saturates and stores each
// score, and tracks a running signed argmax for the final class.
module row_classifier
    import classifier_pkg::*;
#(
    parameter int unsigned NUM_ROWS = NUM_CLASSES,
    parameter int unsigned RESULT_W = 16
) (
    input logic             clk,
    input logic             rst,
    row_classifier_if.slave bus
);

    localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
    localparam logic signed [RESULT_W-1:0] POS_RAIL = {1'b0, {(RESULT_W-1){1'b1}}};
    localparam logic signed [RESULT_W-1:0] NEG_RAIL = {1'b1, {(RESULT_W-1){1'b0}}};

    state_e                      state_q, state_d;
    logic [3:0]                  row_q, row_d;
    logic signed [RESULT_W-1:0]  sat_q, sat_d;
    logic                        any_ovf_q, any_ovf_d;
    logic signed [RESULT_W-1:0]  max_q, max_d;
    logic [3:0]                  max_idx_q, max_idx_d;
    logic                        max_valid_q, max_valid_d;
    logic [3:0]                  class_out_q, class_out_d;
    logic signed [RESULT_W-1:0]  class_score_q, class_score_d;
    logic signed [RESULT_W-1:0]  sat_val;

    // An overflowed sum has the opposite true sign, so clamp toward that rail.
    always_comb begin
        sat_val = bus.row_result;
        if (bus.overflow) begin
            sat_val = bus.row_result[RESULT_W-1] ? POS_RAIL : NEG_RAIL;
        end
    end

    // Next-state and datapath updates for the row sequencer.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        sat_d         = sat_q;
        any_ovf_d     = any_ovf_q;
        max_d         = max_q;
        max_idx_d     = max_idx_q;
        max_valid_d   = max_valid_q;
        class_out_d   = class_out_q;
        class_score_d = class_score_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    row_d         = '0;
                    any_ovf_d     = 1'b0;
                    max_valid_d   = 1'b0;
                    max_d         = '0;
                    max_idx_d     = '0;
                    class_out_d   = '0;
                    class_score_d = '0;
                    state_d       = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.done_row) begin
                    sat_d     = sat_val;
                    any_ovf_d = any_ovf_q | bus.overflow;
                    state_d   = StStore;
                end
            end
            StStore: begin
                // Strict compare so ties keep the lower index.
                if (!max_valid_q || (sat_q > max_q)) begin
                    max_d       = sat_q;
                    max_idx_d   = row_q;
                    max_valid_d = 1'b1;
                end
                state_d = StNext;
            end
            StNext: begin
                if (row_q == LAST_ROW) begin
                    // Load the result here so it is visible alongside done.
                    class_out_d   = max_idx_q;
                    class_score_d = max_q;
                    state_d       = StFin;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = StIssue;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            row_q         <= '0;
            sat_q         <= '0;
            any_ovf_q     <= 1'b0;
            max_q         <= '0;
            max_idx_q     <= '0;
            max_valid_q   <= 1'b0;
            class_out_q   <= '0;
            class_score_q <= '0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            sat_q         <= sat_d;
            any_ovf_q     <= any_ovf_d;
            max_q         <= max_d;
            max_idx_q     <= max_idx_d;
            max_valid_q   <= max_valid_d;
            class_out_q   <= class_out_d;
            class_score_q <= class_score_d;
        end
    end

    // Outputs decoded from state; begin_mult is killed by rst in the same cycle.
    always_comb begin
        bus.row_select   = row_q;
        bus.begin_mult   = (state_q == StIssue) && !rst;
        bus.busy         = (state_q == StIssue) || (state_q == StWait) ||
                           (state_q == StStore) || (state_q == StNext);
        bus.done         = (state_q == StFin);
        bus.class_out    = class_out_q;
        bus.class_score  = class_score_q;
        bus.any_overflow = any_ovf_q;
    end

    score_buffer #(
        .NUM_ROWS (NUM_ROWS),
        .RESULT_W (RESULT_W)
    ) u_score_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (state_q == StStore),
        .waddr (row_q),
        .wdata (sat_q),
        .raddr (bus.score_rd_addr),
        .rdata (bus.score_rd_data)
    );

endmodule

// File: tb/tb_row_classifier.sv
// Bench for row_classifier: table of full-run scenarios, a multiplier model
// that answers begin_mult, and hand sequences for start/done_row/rst corners.
module tb_row_classifier;
    import classifier_pkg::*;

    localparam int unsigned NR  = 10;
    localparam int          LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    row_classifier_if #(.RESULT_W(16)) bus ();

    row_classifier #(
        .NUM_ROWS (NR),
        .RESULT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NR-1:0][15:0] res;
        logic [NR-1:0]       ovf;
        logic [3:0]          cls;
        logic [15:0]         score;
        logic                any;
        logic [3:0]          rd_addr;
        logic [15:0]         rd_exp;
    } vec_t;

    typedef struct {
        logic [3:0]  cls;
        logic [15:0] score;
        logic        any;
    } res_t;

    vec_t       vecs [4];
    res_t       exp_res [$];
    logic [3:0] exp_sel [$];

    logic [NR-1:0][15:0] m_res;
    logic [NR-1:0]       m_ovf;
    int                  hold_row = -1;
    bit                  hold_seen = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiplier model: answers each begin_mult LAT cycles later unless held.
    initial begin
        bus.done_row   = 1'b0;
        bus.row_result = '0;
        bus.overflow   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.begin_mult) begin
                int r;
                r = int'(bus.row_select);
                n_tests++;
                if (exp_sel.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_begin_mult: got row_select %0d expected none", r);
                end else begin
                    logic [3:0] e;
                    e = exp_sel.pop_front();
                    if (bus.row_select !== e) begin
                        n_fail++;
                        $display("FAIL row_select: got %0d expected %0d", bus.row_select, e);
                    end
                end
                if (r == hold_row) begin
                    hold_seen = 1'b1;
                end else begin
                    repeat (LAT) @(negedge clk);
                    bus.done_row   = 1'b1;
                    bus.row_result = m_res[r];
                    bus.overflow   = m_ovf[r];
                    @(negedge clk);
                    bus.done_row   = 1'b0;
                    bus.overflow   = 1'b0;
                    bus.row_result = 16'hDEAD;
                end
            end
        end
    end

    task automatic run_case(input int k, input bit extra_start);
        res_t e;
        int   cyc;
        m_res = vecs[k].res;
        m_ovf = vecs[k].ovf;
        for (int i = 0; i < int'(NR); i++) exp_sel.push_back(4'(i));
        e.cls   = vecs[k].cls;
        e.score = vecs[k].score;
        e.any   = vecs[k].any;
        exp_res.push_back(e);

        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("busy_after_start[%0d]", k), bus.busy, 1);
        if (extra_start) begin
            // Now in ISSUE; one more edge reaches WAIT, then pulse start there.
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end

        cyc = 0;
        while (!bus.done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout[%0d]: got no done expected done within 400 cycles", k);
        end else begin
            e = exp_res.pop_front();
            check($sformatf("class_out[%0d]", k), bus.class_out, e.cls);
            check($sformatf("class_score[%0d]", k), bus.class_score, e.score);
            check($sformatf("any_overflow[%0d]", k), bus.any_overflow, e.any);
            check($sformatf("busy_at_done[%0d]", k), bus.busy, 0);
        end
        @(negedge clk);
        check($sformatf("done_one_cycle[%0d]", k), bus.done, 0);
        check($sformatf("rows_issued[%0d]", k), exp_sel.size(), 0);
        repeat (3) @(negedge clk);
        check($sformatf("class_hold[%0d]", k), bus.class_out, vecs[k].cls);
        check($sformatf("busy_idle[%0d]", k), bus.busy, 0);
        bus.score_rd_addr = vecs[k].rd_addr;
        #1;
        check($sformatf("score_rd[%0d]", k), bus.score_rd_data, vecs[k].rd_exp);
        bus.score_rd_addr = 4'd10;
        #1;
        check($sformatf("score_rd_oor[%0d]", k), bus.score_rd_data, 0);
    endtask

    initial begin
        int cyc;
        // Ascending scores, no overflow.
        for (int i = 0; i < int'(NR); i++) begin
            vecs[0].res[i] = 16'(10 * (i + 1));
            vecs[1].res[i] = 16'd5;
            vecs[2].res[i] = 16'hFFFD;
            vecs[3].res[i] = 16'd0;
        end
        vecs[0].ovf = '0; vecs[0].cls = 4'd9; vecs[0].score = 16'd100; vecs[0].any = 1'b0;
        vecs[0].rd_addr = 4'd3; vecs[0].rd_exp = 16'd40;
        // Negative-looking overflowed row saturates to the positive rail and wins.
        vecs[1].res[4] = 16'h8001; vecs[1].ovf = '0; vecs[1].ovf[4] = 1'b1;
        vecs[1].cls = 4'd4; vecs[1].score = SAT_MAX; vecs[1].any = 1'b1;
        vecs[1].rd_addr = 4'd4; vecs[1].rd_exp = SAT_MAX;
        // Positive-looking overflowed row saturates to the negative rail and loses.
        vecs[2].res[2] = 16'h7000; vecs[2].ovf = '0; vecs[2].ovf[2] = 1'b1;
        vecs[2].cls = 4'd0; vecs[2].score = 16'hFFFD; vecs[2].any = 1'b1;
        vecs[2].rd_addr = 4'd2; vecs[2].rd_exp = SAT_MIN;
        // Tie between rows 1 and 6 keeps row 1.
        vecs[3].res[1] = 16'd500; vecs[3].res[6] = 16'd500; vecs[3].ovf = '0;
        vecs[3].cls = 4'd1; vecs[3].score = 16'd500; vecs[3].any = 1'b0;
        vecs[3].rd_addr = 4'd6; vecs[3].rd_exp = 16'd500;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.score_rd_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_begin_mult", bus.begin_mult, 0);
        check("rst_row_select", bus.row_select, 0);
        check("rst_class_out", bus.class_out, 0);
        check("rst_class_score", bus.class_score, 0);
        check("rst_any_overflow", bus.any_overflow, 0);
        check("rst_score_rd", bus.score_rd_data, 0);

        for (int k = 0; k < 4; k++) run_case(k, 1'b0);

        // Spurious done_row while idle must not write or start anything.
        @(negedge clk);
        bus.done_row   = 1'b1;
        bus.row_result = 16'h7FFF;
        bus.overflow   = 1'b1;
        @(negedge clk);
        bus.done_row   = 1'b0;
        bus.overflow   = 1'b0;
        @(negedge clk);
        check("spurious_busy", bus.busy, 0);
        check("spurious_any_ovf", bus.any_overflow, 0);
        bus.score_rd_addr = 4'd0;
        #1;
        check("spurious_score0", bus.score_rd_data, 0);
        bus.score_rd_addr = 4'd6;
        #1;
        check("spurious_score6", bus.score_rd_data, 16'd500);

        // Extra start during WAIT is ignored: exactly ten rows, normal result.
        run_case(0, 1'b1);

        // Reset while waiting on row 5.
        hold_row  = 5;
        hold_seen = 1'b0;
        m_res = vecs[0].res;
        m_ovf = vecs[0].ovf;
        for (int i = 0; i < int'(NR); i++) exp_sel.push_back(4'(i));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!hold_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!hold_seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL row5_timeout: got no row 5 issue expected it within 400 cycles");
        end
        @(negedge clk);
        check("wait_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_begin_mult", bus.begin_mult, 0);
        check("midrst_row_select", bus.row_select, 0);
        for (int a = 0; a < 16; a++) begin
            bus.score_rd_addr = 4'(a);
            #1;
            check($sformatf("midrst_score[%0d]", a), bus.score_rd_data, 0);
        end
        rst = 1'b0;
        exp_sel.delete();
        hold_row = -1;
        @(negedge clk);
        check("postrst_busy", bus.busy, 0);
        run_case(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
